// File: rtl/pulse_capture.sv
// Single-pulse width capture: arm with trigger, count clk edges with ext_pulse high, latch
// the count on the falling edge and raise an interrupt. Result is read over a tri-state bus.
//
// The interrupt port is named intr because int is a reserved SystemVerilog keyword.

module pulse_capture #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             clr,
  input  logic             trigger,
  input  logic             ext_pulse,
  input  logic             int_clr,
  output logic             intr,
  inout  wire  [WIDTH-1:0] data
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasuring
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] result_q;
  logic             int_flag_q;
  logic             prev_pulse_q;

  logic             pulse_rise;
  logic             counter_max;

  assign pulse_rise  = ext_pulse & ~prev_pulse_q;
  assign counter_max = &counter_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      result_q     <= '0;
      int_flag_q   <= 1'b0;
      prev_pulse_q <= 1'b0;
    end else begin
      // Edge history is tracked in every state so a pulse already high at arm time is skipped.
      prev_pulse_q <= ext_pulse;
      if (trigger) begin
        state_q    <= StArmed;
        counter_q  <= '0;
        int_flag_q <= 1'b0;
      end else begin
        if (int_clr) begin
          int_flag_q <= 1'b0;
        end
        unique case (state_q)
          StIdle: begin
          end
          StArmed: begin
            if (pulse_rise) begin
              state_q   <= StMeasuring;
              counter_q <= WIDTH'(1);
            end
          end
          StMeasuring: begin
            if (ext_pulse) begin
              if (!counter_max) begin
                counter_q <= counter_q + WIDTH'(1);
              end
            end else begin
              // Completion overrides a simultaneous int_clr.
              result_q   <= counter_q;
              int_flag_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign intr = int_flag_q;
  assign data = oe ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture; a narrow second instance exercises counter saturation.
// Both buses carry pull-ups so an undriven bus reads all ones.

module tb_pulse_capture;

  logic        clk;
  logic        rst;
  logic        oe;
  logic        clr;
  logic        trigger;
  logic        ext_pulse;
  logic        int_clr;
  logic        intr;
  logic        intr_n;
  wire  [31:0] data;
  wire  [3:0]  data_n;

  int unsigned n_cmp;
  int unsigned n_bad;

  pullup (data);
  pullup (data_n);

  pulse_capture #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .oe        (oe),
    .clr       (clr),
    .trigger   (trigger),
    .ext_pulse (ext_pulse),
    .int_clr   (int_clr),
    .intr      (intr),
    .data      (data)
  );

  pulse_capture #(.WIDTH(4)) dut_n (
    .clk       (clk),
    .rst       (rst),
    .oe        (oe),
    .clr       (clr),
    .trigger   (trigger),
    .ext_pulse (ext_pulse),
    .int_clr   (int_clr),
    .intr      (intr_n),
    .data      (data_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_int: got %b want 0", intr);
    end
    oe = 1'b1;
    #1;
    n_cmp++;
    if (data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %0d want 0", data);
    end
    oe = 1'b0;
    #1;
    n_cmp++;
    if (data !== 32'hffff_ffff) begin
      n_bad++;
      $display("FAIL reset_hiz: got %h want ffffffff (undriven)", data);
    end
    oe = 1'b1;
    arm();
    tick(2);
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd0) begin
      n_bad++;
      $display("FAIL arm_idle: got int=%b data=%0d want int=0 data=0", intr, data);
    end
  endtask

  task automatic test_capture_1000();
    ext_pulse = 1'b1;
    tick(1000);
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++;
      $display("FAIL cap1000_early_int: got %b want 0", intr);
    end
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b1 || data !== 32'd1000) begin
      n_bad++;
      $display("FAIL cap1000: got int=%b data=%0d want int=1 data=1000", intr, data);
    end
    oe = 1'b0;
    #1;
    n_cmp++;
    if (data !== 32'hffff_ffff) begin
      n_bad++;
      $display("FAIL cap1000_hiz: got %h want ffffffff (undriven)", data);
    end
    oe = 1'b1;
    #1;
  endtask

  task automatic test_rearm_7000();
    tick(1000);
    arm();
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd1000) begin
      n_bad++;
      $display("FAIL rearm_keep: got int=%b data=%0d want int=0 data=1000", intr, data);
    end
    ext_pulse = 1'b1;
    tick(2000);
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd1000) begin
      n_bad++;
      $display("FAIL mid7000: got int=%b data=%0d want int=0 data=1000", intr, data);
    end
    tick(5000);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b1 || data !== 32'd7000) begin
      n_bad++;
      $display("FAIL cap7000: got int=%b data=%0d want int=1 data=7000", intr, data);
    end
  endtask

  task automatic test_high_before_trigger();
    ext_pulse = 1'b1;
    tick(1);
    arm();
    tick(3);
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd7000) begin
      n_bad++;
      $display("FAIL prehigh_ignored: got int=%b data=%0d want int=0 data=7000", intr, data);
    end
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++;
      $display("FAIL prehigh_fall: got int=%b want 0", intr);
    end
    ext_pulse = 1'b1;
    tick(5);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b1 || data !== 32'd5) begin
      n_bad++;
      $display("FAIL cap5: got int=%b data=%0d want int=1 data=5", intr, data);
    end
  endtask

  task automatic test_int_clr();
    int_clr = 1'b1;
    tick(1);
    int_clr = 1'b0;
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd5) begin
      n_bad++;
      $display("FAIL int_clr_alone: got int=%b data=%0d want int=0 data=5", intr, data);
    end
    arm();
    ext_pulse = 1'b1;
    tick(3);
    ext_pulse = 1'b0;
    int_clr   = 1'b1;
    tick(1);
    int_clr = 1'b0;
    n_cmp++;
    if (intr !== 1'b1 || data !== 32'd3) begin
      n_bad++;
      $display("FAIL int_clr_vs_set: got int=%b data=%0d want int=1 data=3", intr, data);
    end
  endtask

  task automatic test_clr();
    arm();
    ext_pulse = 1'b1;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd0) begin
      n_bad++;
      $display("FAIL clr_mid: got int=%b data=%0d want int=0 data=0", intr, data);
    end
    tick(3);
    ext_pulse = 1'b0;
    tick(1);
    ext_pulse = 1'b1;
    tick(3);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd0) begin
      n_bad++;
      $display("FAIL clr_no_capture: got int=%b data=%0d want int=0 data=0", intr, data);
    end
  endtask

  task automatic test_trigger_abort();
    arm();
    ext_pulse = 1'b1;
    tick(4);
    arm();
    tick(2);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b0 || data !== 32'd0) begin
      n_bad++;
      $display("FAIL abort_no_capture: got int=%b data=%0d want int=0 data=0", intr, data);
    end
    ext_pulse = 1'b1;
    tick(2);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr !== 1'b1 || data !== 32'd2) begin
      n_bad++;
      $display("FAIL abort_recapture: got int=%b data=%0d want int=1 data=2", intr, data);
    end
  endtask

  task automatic test_saturation();
    arm();
    ext_pulse = 1'b1;
    tick(14);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr_n !== 1'b1 || data_n !== 4'd14) begin
      n_bad++;
      $display("FAIL sat_below: got int=%b data=%0d want int=1 data=14", intr_n, data_n);
    end
    arm();
    ext_pulse = 1'b1;
    tick(20);
    ext_pulse = 1'b0;
    tick(1);
    n_cmp++;
    if (intr_n !== 1'b1 || data_n !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_clamp: got int=%b data=%0d want int=1 data=15", intr_n, data_n);
    end
    n_cmp++;
    if (data !== 32'd20) begin
      n_bad++;
      $display("FAIL wide_20: got %0d want 20", data);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    oe        = 1'b0;
    clr       = 1'b0;
    trigger   = 1'b0;
    ext_pulse = 1'b0;
    int_clr   = 1'b0;
    test_reset();
    test_capture_1000();
    test_rearm_7000();
    test_high_before_trigger();
    test_int_clr();
    test_clr();
    test_trigger_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
